// File: rtl/regfile_pkg.sv
// Shared register-file types and constants.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [DATA_W-1:0] reg_word_t;
  typedef reg_word_t reg_bank_t [NUM_REGS-1:0];

  // Number of set bits in a busy vector; result fits 0..NUM_REGS.
  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      n = n + {{ADDR_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/decoder5_32.sv
// 5-bit address plus enable to 32-bit one-hot decoder.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // One bit set at addr when enabled, otherwise all zero.
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_scoreboard.sv
// 32x32 register storage with per-register busy scoreboard; register 31 reads as zero.
module reg_bank_scoreboard
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  output reg_bank_t           regs,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_count
);

  localparam logic [NUM_REGS-1:0] LIVE_MASK = ~(NUM_REGS'(1) << ZERO_REG);

  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] issue_sel;
  logic [NUM_REGS-1:0] busy_next;

  decoder5_32 u_wr_dec (
    .addr   (wr_addr),
    .en     (wr_en),
    .onehot (wr_sel)
  );

  decoder5_32 u_issue_dec (
    .addr   (issue_addr),
    .en     (issue_en),
    .onehot (issue_sel)
  );

  // Next scoreboard state: clear on writeback, set on issue (set wins), zero reg never busy.
  always_comb begin
    busy_next = ((busy & ~wr_sel) | issue_sel) & LIVE_MASK;
  end

  // Register storage; the zero register is only ever loaded with zero.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_sel[i] && (i != ZERO_REG)) begin
        regs[i] <= wr_data;
      end
    end
  end

  // Scoreboard and its population count, both registered from the same next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= popcount(busy_next);
    end
  end

endmodule

// File: tb/tb_reg_bank_scoreboard.sv
// Directed self-checking bench for reg_bank_scoreboard.
module tb_reg_bank_scoreboard;
  import regfile_pkg::*;

  logic                clk;
  logic                reset;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                issue_en;
  logic [ADDR_W-1:0]   issue_addr;
  reg_bank_t           regs;
  logic [NUM_REGS-1:0] busy;
  logic [ADDR_W:0]     busy_count;

  int unsigned n_checks;
  int unsigned n_fails;

  reg_bank_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .regs       (regs),
    .busy       (busy),
    .busy_count (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ie, input logic [4:0] ia);
    reset = r; wr_en = we; wr_addr = wa; wr_data = wd; issue_en = ie; issue_addr = ia;
    @(posedge clk);
    #1;
    reset = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
  endtask

  // OR of every register except one index, to confirm nothing else changed.
  function automatic logic [31:0] or_except(input int unsigned skip);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) if (i != skip) acc |= regs[i];
    return acc;
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; issue_en = 1'b0; issue_addr = '0;

    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("init_busy", busy, 32'h0);
    check("init_count", {26'd0, busy_count}, 32'd0);
    check("init_regs", or_except(99), 32'h0);

    // Random traffic, then a single reset cycle must clear everything.
    for (int k = 0; k < 8; k++)
      step(1'b0, 1'b1, 5'($urandom_range(0, 30)), $urandom, 1'b1, 5'($urandom_range(0, 30)));
    step(1'b1, 1'b1, 5'd2, 32'h1111_2222, 1'b1, 5'd6);
    check("rst_regs", or_except(99), 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_count", {26'd0, busy_count}, 32'd0);

    // Write and readback.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    check("wr5", regs[5], 32'hDEADBEEF);
    check("wr5_others", or_except(5), 32'h0);
    check("wr5_busy", busy, 32'h0);
    step(1'b0, 1'b1, 5'd0, 32'h2, 1'b0, 5'd0);
    check("wr0", regs[0], 32'h2);
    check("wr0_keep5", regs[5], 32'hDEADBEEF);

    // Zero register ignores writes and issues.
    step(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31);
    check("zr_reg", regs[31], 32'h0);
    check("zr_busy", busy, 32'h0);
    check("zr_count", {26'd0, busy_count}, 32'd0);

    // Scoreboard lifecycle.
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    check("life_busy2", busy, 32'h88);
    check("life_count2", {26'd0, busy_count}, 32'd2);
    step(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    check("life_busy1", busy, 32'h80);
    check("life_count1", {26'd0, busy_count}, 32'd1);
    check("life_r3", regs[3], 32'h33);
    step(1'b0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    check("life_busy0", busy, 32'h0);
    check("life_count0", {26'd0, busy_count}, 32'd0);

    // Simultaneous set and clear on the same register: set wins.
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    check("sc_pre", busy, 32'h10);
    step(1'b0, 1'b1, 5'd4, 32'd16, 1'b1, 5'd4);
    check("sc_r4", regs[4], 32'd16);
    check("sc_busy", busy, 32'h10);
    check("sc_count", {26'd0, busy_count}, 32'd1);
    step(1'b0, 1'b1, 5'd4, 32'd16, 1'b0, 5'd0);
    check("sc_clr", busy, 32'h0);

    // Write to a non-busy register, and issue/write to different registers together.
    step(1'b0, 1'b1, 5'd20, 32'h1234, 1'b0, 5'd0);
    check("nb_r20", regs[20], 32'h1234);
    check("nb_busy", busy, 32'h0);
    step(1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 5'd12);
    check("diff_r5", regs[5], 32'h55);
    check("diff_busy", busy, 32'h1000);
    check("diff_count", {26'd0, busy_count}, 32'd1);

    // Saturation: every live register busy.
    for (int k = 0; k < 31; k++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(k));
    check("sat_busy", busy, 32'h7FFFFFFF);
    check("sat_count", {26'd0, busy_count}, 32'd31);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
    check("sat_reissue_busy", busy, 32'h7FFFFFFF);
    check("sat_reissue_count", {26'd0, busy_count}, 32'd31);
    step(1'b0, 1'b1, 5'd30, 32'hABCD, 1'b0, 5'd0);
    check("sat_clr30_busy", busy, 32'h3FFFFFFF);
    check("sat_clr30_count", {26'd0, busy_count}, 32'd30);

    // Mid-operation reset discards pending busy bits and data.
    step(1'b1, 1'b1, 5'd1, 32'h9, 1'b1, 5'd2);
    check("mid_rst_busy", busy, 32'h0);
    check("mid_rst_count", {26'd0, busy_count}, 32'd0);
    check("mid_rst_regs", or_except(99), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
